// File: rtl/id_ex_pipe_reg.sv
// rtl/id_ex_pipe_reg.sv - ID/EX pipeline register with stall/flush control and event counters
// Flush beats stall beats load; an invalid slot never carries a register write into execute.
module id_ex_pipe_reg #(
  parameter int              XLEN     = 32,
  parameter int              ALUOP_W  = 5,
  parameter int              CNT_W    = 16,
  parameter logic [XLEN-1:0] NOP_INST = 32'h0000_0013
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               flush,
  input  logic               cnt_clr,
  input  logic               valid_d,
  input  logic               reg_wr,
  input  logic               sel_a,
  input  logic               sel_b,
  input  logic [1:0]         wb_sel,
  input  logic [2:0]         funct3,
  input  logic [ALUOP_W-1:0] alu_op,
  input  logic [6:0]         opcode,
  input  logic [XLEN-1:0]    addr_d,
  input  logic [XLEN-1:0]    rdata1,
  input  logic [XLEN-1:0]    rdata2,
  input  logic [XLEN-1:0]    imm_d,
  input  logic [XLEN-1:0]    inst_d,
  output logic               valid_e,
  output logic               reg_wr_e,
  output logic               sel_a_e,
  output logic               sel_b_e,
  output logic [1:0]         wb_sel_e,
  output logic [2:0]         funct3_e,
  output logic [ALUOP_W-1:0] alu_op_e,
  output logic [6:0]         opcode_e,
  output logic [XLEN-1:0]    addr_e,
  output logic [XLEN-1:0]    rdata1_e,
  output logic [XLEN-1:0]    rdata2_e,
  output logic [XLEN-1:0]    imm_e,
  output logic [XLEN-1:0]    inst_e,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);

  typedef struct packed {
    logic               valid;
    logic               reg_wr;
    logic               sel_a;
    logic               sel_b;
    logic [1:0]         wb_sel;
    logic [2:0]         funct3;
    logic [ALUOP_W-1:0] alu_op;
    logic [6:0]         opcode;
    logic [XLEN-1:0]    addr;
    logic [XLEN-1:0]    rdata1;
    logic [XLEN-1:0]    rdata2;
    logic [XLEN-1:0]    imm;
    logic [XLEN-1:0]    inst;
  } stage_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  function automatic stage_t bubble();
    stage_t b;
    b        = '0;
    b.opcode = 7'h13;
    b.inst   = NOP_INST;
    return b;
  endfunction

  stage_t           stage_q, stage_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stage_d = stage_q;
    if (flush) begin
      stage_d = bubble();
    end else if (!stall) begin
      stage_d.valid  = valid_d;
      stage_d.reg_wr = reg_wr & valid_d;
      stage_d.sel_a  = sel_a;
      stage_d.sel_b  = sel_b;
      stage_d.wb_sel = wb_sel;
      stage_d.funct3 = funct3;
      stage_d.alu_op = alu_op;
      stage_d.opcode = opcode;
      stage_d.addr   = addr_d;
      stage_d.rdata1 = rdata1;
      stage_d.rdata2 = rdata2;
      stage_d.imm    = imm_d;
      stage_d.inst   = inst_d;
    end
  end

  // Only a valid instruction held or discarded is an event worth counting.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (cnt_clr) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (flush && stage_q.valid && (flush_cnt_q != CNT_MAX)) begin
        flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
      if (stall && !flush && stage_q.valid && (stall_cnt_q != CNT_MAX)) begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q     <= bubble();
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stage_q     <= stage_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign valid_e   = stage_q.valid;
  assign reg_wr_e  = stage_q.reg_wr;
  assign sel_a_e   = stage_q.sel_a;
  assign sel_b_e   = stage_q.sel_b;
  assign wb_sel_e  = stage_q.wb_sel;
  assign funct3_e  = stage_q.funct3;
  assign alu_op_e  = stage_q.alu_op;
  assign opcode_e  = stage_q.opcode;
  assign addr_e    = stage_q.addr;
  assign rdata1_e  = stage_q.rdata1;
  assign rdata2_e  = stage_q.rdata2;
  assign imm_e     = stage_q.imm;
  assign inst_e    = stage_q.inst;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// tb/tb_id_ex_pipe_reg.sv - scoreboard bench for id_ex_pipe_reg (CNT_W=4)
module tb_id_ex_pipe_reg;

  typedef struct packed {
    logic        valid;
    logic        reg_wr;
    logic        sel_a;
    logic        sel_b;
    logic [1:0]  wb_sel;
    logic [2:0]  funct3;
    logic [4:0]  alu_op;
    logic [6:0]  opcode;
    logic [31:0] addr;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [31:0] inst;
  } vec_t;

  typedef struct {
    string      tag;
    vec_t       v;
    logic [3:0] sc;
    logic [3:0] fc;
  } exp_t;

  logic clk = 1'b0;
  logic rst, stall, flush, cnt_clr;
  logic valid_d, reg_wr, sel_a, sel_b;
  logic [1:0] wb_sel;
  logic [2:0] funct3;
  logic [4:0] alu_op;
  logic [6:0] opcode;
  logic [31:0] addr_d, rdata1, rdata2, imm_d, inst_d;
  logic valid_e, reg_wr_e, sel_a_e, sel_b_e;
  logic [1:0] wb_sel_e;
  logic [2:0] funct3_e;
  logic [4:0] alu_op_e;
  logic [6:0] opcode_e;
  logic [31:0] addr_e, rdata1_e, rdata2_e, imm_e, inst_e;
  logic [3:0] stall_cnt, flush_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  id_ex_pipe_reg #(.XLEN(32), .ALUOP_W(5), .CNT_W(4), .NOP_INST(32'h0000_0013)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
    .valid_d(valid_d), .reg_wr(reg_wr), .sel_a(sel_a), .sel_b(sel_b),
    .wb_sel(wb_sel), .funct3(funct3), .alu_op(alu_op), .opcode(opcode),
    .addr_d(addr_d), .rdata1(rdata1), .rdata2(rdata2), .imm_d(imm_d), .inst_d(inst_d),
    .valid_e(valid_e), .reg_wr_e(reg_wr_e), .sel_a_e(sel_a_e), .sel_b_e(sel_b_e),
    .wb_sel_e(wb_sel_e), .funct3_e(funct3_e), .alu_op_e(alu_op_e), .opcode_e(opcode_e),
    .addr_e(addr_e), .rdata1_e(rdata1_e), .rdata2_e(rdata2_e), .imm_e(imm_e), .inst_e(inst_e),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  function automatic void cmp(string tag, string f, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s.%s: got %h expected %h", tag, f, act, exp);
    end
  endfunction

  // Monitor: the stage presents its state every cycle; check whatever is queued.
  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      exp_t e;
      e = sb_q.pop_front();
      cmp(e.tag, "valid_e",   32'(valid_e),   32'(e.v.valid));
      cmp(e.tag, "reg_wr_e",  32'(reg_wr_e),  32'(e.v.reg_wr));
      cmp(e.tag, "sel_a_e",   32'(sel_a_e),   32'(e.v.sel_a));
      cmp(e.tag, "sel_b_e",   32'(sel_b_e),   32'(e.v.sel_b));
      cmp(e.tag, "wb_sel_e",  32'(wb_sel_e),  32'(e.v.wb_sel));
      cmp(e.tag, "funct3_e",  32'(funct3_e),  32'(e.v.funct3));
      cmp(e.tag, "alu_op_e",  32'(alu_op_e),  32'(e.v.alu_op));
      cmp(e.tag, "opcode_e",  32'(opcode_e),  32'(e.v.opcode));
      cmp(e.tag, "addr_e",    addr_e,         e.v.addr);
      cmp(e.tag, "rdata1_e",  rdata1_e,       e.v.rs1);
      cmp(e.tag, "rdata2_e",  rdata2_e,       e.v.rs2);
      cmp(e.tag, "imm_e",     imm_e,          e.v.imm);
      cmp(e.tag, "inst_e",    inst_e,         e.v.inst);
      cmp(e.tag, "stall_cnt", 32'(stall_cnt), 32'(e.sc));
      cmp(e.tag, "flush_cnt", 32'(flush_cnt), 32'(e.fc));
    end
  end

  task automatic apply(input vec_t v);
    valid_d = v.valid;  reg_wr = v.reg_wr;  sel_a = v.sel_a;   sel_b = v.sel_b;
    wb_sel  = v.wb_sel; funct3 = v.funct3;  alu_op = v.alu_op; opcode = v.opcode;
    addr_d  = v.addr;   rdata1 = v.rs1;     rdata2 = v.rs2;    imm_d = v.imm;
    inst_d  = v.inst;
  endtask

  task automatic push(input string tag, input vec_t v, input logic [3:0] sc, input logic [3:0] fc);
    exp_t e;
    e.tag = tag; e.v = v; e.sc = sc; e.fc = fc;
    sb_q.push_back(e);
  endtask

  // One clock edge, then queue what the stage must show after it.
  task automatic step(input string tag, input vec_t v, input logic [3:0] sc, input logic [3:0] fc);
    @(posedge clk);
    #1;
    push(tag, v, sc, fc);
    @(negedge clk);
    #1;
  endtask

  vec_t bub, r_v, a_v, b_v, c_v, c_exp;

  initial begin
    bub = '{valid: 1'b0, reg_wr: 1'b0, sel_a: 1'b0, sel_b: 1'b0, wb_sel: 2'd0, funct3: 3'd0,
            alu_op: 5'd0, opcode: 7'h13, addr: 32'h0, rs1: 32'h0, rs2: 32'h0, imm: 32'h0,
            inst: 32'h0000_0013};
    r_v = '{valid: 1'b1, reg_wr: 1'b1, sel_a: 1'b0, sel_b: 1'b1, wb_sel: 2'd1, funct3: 3'd0,
            alu_op: 5'h01, opcode: 7'h13, addr: 32'h0000_0040, rs1: 32'h0, rs2: 32'h0,
            imm: 32'h0000_000A, inst: 32'h00A0_0093};
    a_v = '{valid: 1'b1, reg_wr: 1'b1, sel_a: 1'b1, sel_b: 1'b0, wb_sel: 2'd2, funct3: 3'd5,
            alu_op: 5'h0A, opcode: 7'h13, addr: 32'h0000_0100, rs1: 32'h1111_1111,
            rs2: 32'h2222_2222, imm: 32'h0000_0005, inst: 32'h0050_0113};
    b_v = '{valid: 1'b1, reg_wr: 1'b0, sel_a: 1'b0, sel_b: 1'b1, wb_sel: 2'd3, funct3: 3'd7,
            alu_op: 5'h1F, opcode: 7'h33, addr: 32'h0000_0200, rs1: 32'hDEAD_BEEF,
            rs2: 32'hCAFE_F00D, imm: 32'hFFFF_FFFF, inst: 32'h0020_81B3};
    c_v = '{valid: 1'b0, reg_wr: 1'b1, sel_a: 1'b1, sel_b: 1'b1, wb_sel: 2'd1, funct3: 3'd2,
            alu_op: 5'h03, opcode: 7'h03, addr: 32'h0000_0304, rs1: 32'h0000_0ABC,
            rs2: 32'h0000_0DEF, imm: 32'h0000_0010, inst: 32'h0101_2183};
    c_exp = c_v;
    c_exp.reg_wr = 1'b0;

    // Reset held with every control asserted: all of it ignored.
    rst = 1'b1; stall = 1'b1; flush = 1'b1; cnt_clr = 1'b1;
    apply(a_v);
    @(negedge clk); #1;
    step("rst_hold", bub, 4'd0, 4'd0);

    rst = 1'b0; stall = 1'b0; flush = 1'b0; cnt_clr = 1'b0;
    apply(r_v);
    step("load_r", r_v, 4'd0, 4'd0);
    stall = 1'b1;
    apply(b_v);
    step("stall_r", r_v, 4'd1, 4'd0);

    // Asynchronous reset between edges while stalled with a valid instruction.
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    push("rst_async", bub, 4'd0, 4'd0);
    @(negedge clk); #1;
    rst = 1'b0;
    step("post_rst_stall", bub, 4'd0, 4'd0);

    stall = 1'b0;
    apply(a_v);
    step("load_a", a_v, 4'd0, 4'd0);
    stall = 1'b1;
    apply(b_v);
    step("stall_1", a_v, 4'd1, 4'd0);
    apply(c_v);
    step("stall_2", a_v, 4'd2, 4'd0);
    apply(r_v);
    step("stall_3", a_v, 4'd3, 4'd0);

    flush = 1'b1;
    step("flush_stall", bub, 4'd3, 4'd1);
    stall = 1'b0;
    step("flush_bubble", bub, 4'd3, 4'd1);

    flush = 1'b0;
    apply(c_v);
    step("invalid_slot", c_exp, 4'd3, 4'd1);
    stall = 1'b1;
    apply(a_v);
    step("stall_invalid", c_exp, 4'd3, 4'd1);

    stall = 1'b0;
    step("reload_a", a_v, 4'd3, 4'd1);
    stall = 1'b1;
    apply(b_v);
    for (int i = 1; i <= 20; i++) begin
      step($sformatf("sat_%0d", i), a_v, (3 + i > 15) ? 4'd15 : 4'(3 + i), 4'd1);
    end
    cnt_clr = 1'b1;
    step("clr_on_stall", a_v, 4'd0, 4'd0);

    cnt_clr = 1'b0;
    flush = 1'b1;
    stall = 1'b0;
    step("flush_valid", bub, 4'd0, 4'd1);
    flush = 1'b0;
    apply(a_v);
    step("load_a2", a_v, 4'd0, 4'd1);
    flush = 1'b1;
    cnt_clr = 1'b1;
    step("clr_over_flush", bub, 4'd0, 4'd0);
    flush = 1'b0;
    cnt_clr = 1'b0;

    for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge clk);
    if (sb_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d entries left expected 0", sb_q.size());
    end
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
